fetch_queue: RTL

- Instruction fetch stage directly downstream of the program counter.
- Issues one instruction-memory read per PC value and tracks responses in order.
- Buffers up to DEPTH fetched instructions, each tagged with its PC, and hands them to decode over a valid/ready handshake.
- Holds the PC when memory or the buffer cannot accept a request, and discards in-flight and buffered fetches on a control-flow redirect.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_ptrs.sv | 79 +++++++
 rtl/fetch_queue.sv | 78 +++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths,
// word-alignment mask and the buffered entry layout.
package fetch_queue_pkg;

  localparam int FQ_ADDR_W  = 32;
  localparam int FQ_DATA_W  = 32;
  localparam int ALIGN_LSBS = 2;

  // Clears the byte offset within a 32-bit instruction word.
  localparam logic [FQ_ADDR_W-1:0] WORD_ALIGN_MASK = ~FQ_ADDR_W'((1 << ALIGN_LSBS) - 1);

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_DATA_W-1:0] data;
    logic                 filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ptrs.sv
// Head/tail/fill pointers, occupancy and flushed-response credit for the
// fetch queue. Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue_ptrs #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc,
  input  logic             pop,
  input  logic             resp_valid,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W-1:0] fill,
  output logic [CNT_W-1:0] count,
  output logic             credit,
  output logic             fill_en
);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] pending_reg, pending_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  // Outstanding reads (live or flushed) must never exceed the entry count.
  assign credit  = ({1'b0, count_reg} + {1'b0, drop_cnt_reg}) < (CNT_W + 1)'(DEPTH);
  assign fill_en = resp_valid & ~flush & (drop_cnt_reg == '0);

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    fill_next     = fill_reg;
    count_next    = count_reg;
    pending_next  = pending_reg;
    drop_cnt_next = drop_cnt_reg;
    if (flush) begin
      head_next     = tail_reg;
      fill_next     = tail_reg;
      count_next    = '0;
      pending_next  = '0;
      drop_cnt_next = drop_cnt_reg + pending_reg - CNT_W'(resp_valid);
    end else begin
      if (alloc)   tail_next = tail_reg + PTR_W'(1);
      if (pop)     head_next = head_reg + PTR_W'(1);
      if (fill_en) fill_next = fill_reg + PTR_W'(1);
      if (resp_valid && drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - CNT_W'(1);
      count_next   = count_reg + CNT_W'(alloc) - CNT_W'(pop);
      pending_next = pending_reg + CNT_W'(alloc) - CNT_W'(fill_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_reg     <= '0;
      count_reg    <= '0;
      pending_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      fill_reg     <= fill_next;
      count_reg    <= count_next;
      pending_reg  <= pending_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign fill  = fill_reg;
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one read per PC, buffers in-order responses
// tagged with their PC and presents them to decode. ADDR_W/DATA_W <= package widths.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int DATA_W = FQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_hold,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head, tail, fill;
  logic [CNT_W-1:0] count;
  logic             credit, fill_en, alloc, pop;
  fetch_entry_t     entries [DEPTH];
  fetch_entry_t     head_entry;

  fetch_queue_ptrs #(.DEPTH(DEPTH)) u_ptrs (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .alloc      (alloc),
    .pop        (pop),
    .resp_valid (imem_resp_valid),
    .head       (head),
    .tail       (tail),
    .fill       (fill),
    .count      (count),
    .credit     (credit),
    .fill_en    (fill_en)
  );

  assign imem_req_valid = reset & ~flush & credit;
  assign imem_req_addr  = pc & ~ADDR_W'(~WORD_ALIGN_MASK);
  assign alloc          = imem_req_valid & imem_req_ready;
  assign pc_hold        = ~reset | (~flush & ~alloc);

  // Alloc targets a free slot and fill targets an allocated-unfilled slot,
  // so the two never hit the same entry in one cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_entry_t entry_reg;
    always_ff @(posedge clk) begin
      if (!reset || flush) begin
        entry_reg.filled <= 1'b0;
      end else if (alloc && tail == PTR_W'(gi)) begin
        entry_reg <= '{pc: FQ_ADDR_W'(pc), data: '0, filled: 1'b0};
      end else if (fill_en && fill == PTR_W'(gi)) begin
        entry_reg.data   <= FQ_DATA_W'(imem_resp_data);
        entry_reg.filled <= 1'b1;
      end
    end
    assign entries[gi] = entry_reg;
  end

  assign head_entry = entries[head];
  assign inst_valid = reset & ~flush & (count != '0) & head_entry.filled;
  assign inst_data  = DATA_W'(head_entry.data);
  assign inst_pc    = ADDR_W'(head_entry.pc);
  assign pop        = inst_valid & inst_ready;

endmodule
